// File: rtl/rob_mw.sv
// rob_mw: multi-port reorder buffer; out-of-order writeback, in-order retirement of up to COMMIT_W entries.
// Optional macro ROB_WB_GUARD_EN adds a sticky wb_err flag for writebacks to slots that are not in flight.
module rob_mw #(
    parameter int ROB_NUM_BITS = 4,
    parameter int DATA_W       = 64,
    parameter int RES_W        = 32,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             alloc_valid,
    input  logic [DATA_W-1:0]                alloc_data,
    output logic                             alloc_ready,
    output logic [ROB_NUM_BITS-1:0]          alloc_idx,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*ROB_NUM_BITS-1:0] wb_idx,
    input  logic [WB_PORTS*RES_W-1:0]        wb_result,
    input  logic [WB_PORTS-1:0]              wb_mispredict,
    input  logic                             commit_ready,
    output logic [COMMIT_W-1:0]              commit_valid,
    output logic [COMMIT_W*DATA_W-1:0]       commit_data,
    output logic [COMMIT_W*RES_W-1:0]        commit_result,
    output logic                             flush,
`ifdef ROB_WB_GUARD_EN
    output logic                             wb_err,
`endif
    output logic [ROB_NUM_BITS:0]            count
);
    localparam int NB    = ROB_NUM_BITS;
    localparam int PW    = ROB_NUM_BITS + 1;
    localparam int DEPTH = 1 << ROB_NUM_BITS;

    logic [PW-1:0]     head_reg, tail_reg, count_reg, head_next, occ, n_ret;
    logic [DEPTH-1:0]  done_reg, misp_reg;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [RES_W-1:0]  res_mem [DEPTH];
    logic              full, alloc_fire;

    logic [COMMIT_W-1:0] slot_ok, slot_misp;
    logic [NB-1:0]       slot_idx [COMMIT_W];

    logic [NB-1:0]       wb_idx_p [WB_PORTS];
    logic [NB-1:0]       wb_off [WB_PORTS];
    logic [WB_PORTS-1:0] wb_inflight, wb_acc;

    assign occ         = tail_reg - head_reg;
    assign full        = (head_reg[NB-1:0] == tail_reg[NB-1:0]) && (head_reg[NB] != tail_reg[NB]);
    assign alloc_ready = ~full & ~flush;
    assign alloc_idx   = tail_reg[NB-1:0];
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign count       = count_reg;

    generate
        for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_slot
            assign slot_idx[gi]  = head_reg[NB-1:0] + NB'(gi);
            assign slot_ok[gi]   = (PW'(gi) < occ) && done_reg[slot_idx[gi]];
            assign slot_misp[gi] = misp_reg[slot_idx[gi]];
            assign commit_data[gi*DATA_W +: DATA_W] = data_mem[slot_idx[gi]];
            assign commit_result[gi*RES_W +: RES_W] = res_mem[slot_idx[gi]];
        end
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb
            assign wb_idx_p[gi]    = wb_idx[gi*NB +: NB];
            assign wb_off[gi]      = wb_idx_p[gi] - head_reg[NB-1:0];
            assign wb_inflight[gi] = {1'b0, wb_off[gi]} < occ;
        end
    endgenerate

    // Retirement chain stops after the first not-ready slot and just after a mispredict.
    always_comb begin
        logic chain;
        commit_valid = '0;
        n_ret        = '0;
        chain        = commit_ready;
        for (int k = 0; k < COMMIT_W; k++) begin
            chain           = chain & slot_ok[k];
            commit_valid[k] = chain;
            n_ret           = n_ret + PW'(chain);
            chain           = chain & ~slot_misp[k];
        end
    end

    assign flush     = |(commit_valid & slot_misp);
    assign head_next = head_reg + n_ret;

    always_comb begin
        wb_acc = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_acc[p] = wb_valid[p] & wb_inflight[p] & ~done_reg[wb_idx_p[p]] & ~flush;
            for (int j = 0; j < p; j++) begin
                if (wb_valid[j] && (wb_idx_p[j] == wb_idx_p[p]))
                    wb_acc[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            done_reg  <= '0;
            misp_reg  <= '0;
        end else begin
            head_reg <= head_next;
            if (flush) begin
                tail_reg  <= head_next;
                count_reg <= '0;
                done_reg  <= '0;
            end else begin
                if (alloc_fire) begin
                    tail_reg                     <= tail_reg + PW'(1);
                    done_reg[tail_reg[NB-1:0]]   <= 1'b0;
                    misp_reg[tail_reg[NB-1:0]]   <= 1'b0;
                end
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_acc[p]) begin
                        done_reg[wb_idx_p[p]] <= 1'b1;
                        misp_reg[wb_idx_p[p]] <= wb_mispredict[p];
                    end
                end
                count_reg <= count_reg + PW'(alloc_fire) - n_ret;
            end
        end
    end

    // Payload and result storage carry no reset; validity lives in the pointers and done bits.
    always_ff @(posedge clk) begin
        if (alloc_fire)
            data_mem[tail_reg[NB-1:0]] <= alloc_data;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_acc[p])
                res_mem[wb_idx_p[p]] <= wb_result[p*RES_W +: RES_W];
        end
    end

`ifdef ROB_WB_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_err <= 1'b0;
        else if (|(wb_valid & ~wb_inflight))
            wb_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rob_mw.sv
// tb_rob_mw: scoreboard bench for rob_mw; program-order queue of slot indices checked against retirements.
// Build with ROB_WB_GUARD_EN defined to also exercise wb_err.
module tb_rob_mw;
    localparam int NB = 4, DW = 64, RW = 32, WB = 2, CW = 2, DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 alloc_valid = 1'b0;
    logic [DW-1:0]        alloc_data = '0;
    logic                 alloc_ready;
    logic [NB-1:0]        alloc_idx;
    logic [WB-1:0]        wb_valid = '0;
    logic [WB*NB-1:0]     wb_idx = '0;
    logic [WB*RW-1:0]     wb_result = '0;
    logic [WB-1:0]        wb_mispredict = '0;
    logic                 commit_ready = 1'b1;
    logic [CW-1:0]        commit_valid;
    logic [CW*DW-1:0]     commit_data;
    logic [CW*RW-1:0]     commit_result;
    logic                 flush;
    logic [NB:0]          count;
`ifdef ROB_WB_GUARD_EN
    logic                 wb_err;
`endif

    rob_mw #(.ROB_NUM_BITS(NB), .DATA_W(DW), .RES_W(RW), .WB_PORTS(WB), .COMMIT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_data(alloc_data),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result), .wb_mispredict(wb_mispredict),
        .commit_ready(commit_ready), .commit_valid(commit_valid),
        .commit_data(commit_data), .commit_result(commit_result),
        .flush(flush),
`ifdef ROB_WB_GUARD_EN
        .wb_err(wb_err),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0, n_fail = 0, n_commits = 0, exp_count = 0, exp_tail = 0;
    int            sb_q[$];
    logic [DW-1:0] exp_data [DEPTH];
    logic [RW-1:0] exp_res [DEPTH];
    bit            exp_done [DEPTH];
    bit            exp_misp [DEPTH];
    bit [WB-1:0]   pend_v = '0;
    int            pend_idx [WB];
    logic [RW-1:0] pend_res [WB];
    bit            pend_m [WB];
    logic [CW-1:0] obs_cv;
    logic          obs_flush;
    logic [31:0]   seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input int idx);
        foreach (sb_q[i]) if (sb_q[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic monitor();
        int ncommit, idx, p;
        bit exp_flush, gap, exp_ok;
        ncommit = 0; exp_flush = 0; gap = 0; exp_ok = 0;
        check("count", count, exp_count);
        obs_cv    = commit_valid;
        obs_flush = flush;
        if (!commit_ready) check("hold_cv", commit_valid, 0);
        for (int k = 0; k < CW; k++) begin
            if (!commit_valid[k]) begin
                gap = 1;
                continue;
            end
            if (gap || exp_flush || sb_q.size() == 0 || !exp_done[sb_q[0]]) begin
                check("spurious_commit", commit_valid[k], 1'b0);
                continue;
            end
            idx = sb_q.pop_front();
            check("c_data", commit_data[k*DW +: DW], exp_data[idx]);
            check("c_res", commit_result[k*RW +: RW], exp_res[idx]);
            $display("commit slot=%0d idx=%0d data=%h res=%h", k, idx, commit_data[k*DW +: DW], commit_result[k*RW +: RW]);
            ncommit++;
            n_commits++;
            if (exp_misp[idx]) begin
                exp_flush = 1;
                exp_tail  = (idx + 1) % DEPTH;
            end
        end
        if (exp_flush) sb_q.delete();
        check("flush", flush, exp_flush);
        if (!exp_flush) begin
            for (p = 0; p < WB; p++) begin
                if (pend_v[p] && in_q(pend_idx[p]) && !exp_done[pend_idx[p]]) begin
                    exp_done[pend_idx[p]] = 1;
                    exp_res[pend_idx[p]]  = pend_res[p];
                    exp_misp[pend_idx[p]] = pend_m[p];
                end
            end
        end
        if (alloc_valid) begin
            exp_ok = (exp_count < DEPTH) && !exp_flush;
            check("alloc_ready", alloc_ready, exp_ok);
            if (exp_ok) begin
                check("alloc_idx", alloc_idx, exp_tail);
                sb_q.push_back(exp_tail);
                exp_data[exp_tail] = alloc_data;
                exp_done[exp_tail] = 0;
                exp_misp[exp_tail] = 0;
                exp_tail = (exp_tail + 1) % DEPTH;
            end
        end
        exp_count = exp_flush ? 0 : exp_count - ncommit + int'(exp_ok);
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) monitor();
        @(posedge clk);
        #1;
        alloc_valid   = 1'b0;
        wb_valid      = '0;
        wb_mispredict = '0;
        pend_v        = '0;
    endtask

    task automatic do_alloc();
        alloc_valid = 1'b1;
        alloc_data  = {32'hDA7A_0000, seq};
        seq++;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [RW-1:0] res, input bit m);
        wb_valid[p]            = 1'b1;
        wb_idx[p*NB +: NB]     = NB'(idx);
        wb_result[p*RW +: RW]  = res;
        wb_mispredict[p]       = m;
        pend_v[p]   = 1'b1;
        pend_idx[p] = idx;
        pend_res[p] = res;
        pend_m[p]   = m;
    endtask

    task automatic wb_all();
        int todo[$];
        foreach (sb_q[i]) if (!exp_done[sb_q[i]]) todo.push_back(sb_q[i]);
        while (todo.size() > 0) begin
            for (int p = 0; p < WB && todo.size() > 0; p++) set_wb(p, todo.pop_front(), $urandom, 1'b0);
            step();
        end
    endtask

    task automatic drain(input string tag);
        wb_all();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) step();
        check({tag, "_left"}, sb_q.size(), 0);
        step();
        check({tag, "_count"}, count, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_cv", commit_valid, 0);
        check("rst_flush", flush, 0);
`ifdef ROB_WB_GUARD_EN
        check("rst_wb_err", wb_err, 0);
`endif
        sb_q.delete();
        exp_tail  = 0;
        exp_count = 0;
        for (int i = 0; i < DEPTH; i++) exp_done[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // In-order retirement of out-of-order completions
        do_reset();
        repeat (3) begin do_alloc(); step(); end
        base = n_commits;
        set_wb(0, 2, 32'h2222, 0); step();
        set_wb(0, 0, 32'h0000_1000, 0); step();
        set_wb(0, 1, 32'h1111, 0); step();
        repeat (6) step();
        check("t1_commits", n_commits - base, 3);
        check("t1_count", count, 0);

        // Fill to full from a non-zero head (wraps), drop the 17th, refill after one retirement
        repeat (16) begin do_alloc(); step(); end
        check("t2_count", count, 16);
        check("t2_full_ready", alloc_ready, 0);
        do_alloc(); step();
        set_wb(0, sb_q[0], 32'h5A5A, 0); step();
        do_alloc(); step();
        check("t2_ready_after", alloc_ready, 1);
        do_alloc(); step();
        check("t2_count_refill", count, 16);
        drain("t2");

        // Same index on both ports: port 0 wins; later writeback to a done slot is ignored
        do_reset();
        repeat (6) begin do_alloc(); step(); end
        set_wb(0, 5, 32'hAAAA, 0); set_wb(1, 5, 32'hBBBB, 0); step();
        set_wb(0, 5, 32'hCCCC, 0); step();
        drain("t3");

        // Mispredict retires as last slot and squashes younger entries
        do_reset();
        repeat (6) begin do_alloc(); step(); end
        set_wb(0, 0, 32'h0A0A, 0); set_wb(1, 1, 32'h1B1B, 1); step();
        step();
        check("t4_cv", obs_cv, 2'b11);
        check("t4_flush", obs_flush, 1);
        check("t4_count", count, 0);
        check("t4_alloc_idx", alloc_idx, 2);
        do_alloc(); step();
        drain("t4");

        // Commit back-pressure holds state, release retires two per cycle
        do_reset();
        commit_ready = 1'b0;
        repeat (4) begin do_alloc(); step(); end
        wb_all();
        repeat (3) begin
            step();
            check("t5_cv_hold", obs_cv, 0);
            check("t5_count_hold", count, 4);
        end
        commit_ready = 1'b1;
        step(); check("t5_rel1", obs_cv, 2'b11);
        step(); check("t5_rel2", obs_cv, 2'b11);
        step(); check("t5_count", count, 0);

        // Writeback to a slot that is not in flight is dropped
        do_reset();
        set_wb(0, 7, 32'h7777, 0); step();
`ifdef ROB_WB_GUARD_EN
        check("t6_wb_err", wb_err, 1);
`endif
        repeat (2) step();
`ifdef ROB_WB_GUARD_EN
        check("t6_wb_err_sticky", wb_err, 1);
`endif
        repeat (8) begin do_alloc(); step(); end
        for (int i = 0; i < 7; i += 2) begin
            set_wb(0, i, $urandom, 0);
            if (i + 1 < 7) set_wb(1, i + 1, $urandom, 0);
            step();
        end
        repeat (6) step();
        check("t6_idx7_pending", count, 1);
        drain("t6");
`ifdef ROB_WB_GUARD_EN
        check("t6_wb_err_end", wb_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_mw.md
# rob_mw

Parametrised multi-port reorder buffer: allocates one instruction per cycle from rename, accepts out-of-order completions on `WB_PORTS` writeback ports, and retires up to `COMMIT_W` completed entries per cycle in program order. It sits between rename/dispatch and commit and replaces the single-port, single-commit ROB. New capabilities are:
- configurable depth, payload and result widths;
- multiple completion ports;
- a commit back-pressure input;
- squash of all younger entries when a mispredicted branch retires.

## Interface
Parameters:
- `ROB_NUM_BITS`, 4 — log2 of depth (depth = 16).
- `DATA_W`, 64 — opaque instruction payload width.
- `RES_W`, 32 — result width.
- `WB_PORTS`, 2 — number of completion ports (1..4).
- `COMMIT_W`, 2 — maximum retirements per cycle (1..4, ≤ depth).

Ports:
- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `alloc_valid`  in  1  — rename pushes one entry.
- `alloc_data`  in  DATA_W  — payload for the new entry.
- `alloc_ready`  out  1  — entry accepted this cycle.
- `alloc_idx`  out  ROB_NUM_BITS  — slot index assigned to the entry; valid whenever `alloc_ready`.
- `wb_valid`  in  WB_PORTS  — per-port completion strobe.
- `wb_idx`  in  WB_PORTS*ROB_NUM_BITS  — per-port slot index.
- `wb_result`  in  WB_PORTS*RES_W  — per-port result.
- `wb_mispredict`  in  WB_PORTS  — per-port flag: the completing branch was mispredicted.
- `commit_ready`  in  1  — commit stage can accept retirements this cycle.
- `commit_valid`  out  COMMIT_W  — per-slot retirement; always a contiguous run starting at bit 0.
- `commit_data`  out  COMMIT_W*DATA_W  — payload of each retiring slot.
- `commit_result`  out  COMMIT_W*RES_W  — result of each retiring slot.
- `flush`  out  1  — highest valid commit slot is a mispredict; all younger entries are squashed.
- `count`  out  ROB_NUM_BITS+1  — occupied entries, registered.

## Operation
Pointers and full/empty:
- head and tail are ROB_NUM_BITS+1 bits wide; the MSB is the wrap bit.
- empty = pointers equal.
- full = index bits equal and wrap bits differ.
- `alloc_ready = ~full & ~flush`.

Allocation:
- An entry is written at `tail` with done=0 and mispredict=0.
- tail advances by 1.

Writeback:
- An index is in flight iff it lies in [head, tail) modulo wrap.
- For an in-flight, not-done slot, a writeback sets done=1 and stores the result and mispredict flag.
- A writeback to a slot that is already done is ignored.
- If two ports hit the same index in one cycle, the lowest-numbered port wins.

Commit, per slot k in 0..COMMIT_W-1:
- Slot k is valid iff all of the following hold:
  - `commit_ready` is high;
  - slots 0..k-1 are valid;
  - entry head+k is occupied and done;
  - no lower slot carries a mispredict.
- Head advances by the number of valid slots.

Flush:
- A mispredicted entry retires normally as the last valid slot of its cycle.
- `flush` is combinational, asserted in that same cycle.
- On that edge: tail ← new head, count ← 0, all done bits are cleared, and any allocation or writeback in that cycle is discarded.

Count:
- count_next = count + alloc − retired.
- count_next = 0 on flush.

## Timing
- Reset values: head = tail = 0, all done bits = 0, `count` = 0, `alloc_ready` = 1, `alloc_idx` = 0, `commit_valid` = 0, `flush` = 0.
- Reset asserted mid-operation discards every entry immediately; reset is asynchronous.
- Allocate at edge N; writeback is legal from cycle N+1; retire earliest at edge N+2.
- The minimum alloc→commit latency is therefore 2 cycles.
- The done bit is registered: no same-cycle writeback→commit bypass.
- Full with a retirement in the same cycle: `alloc_ready` stays 0; the freed slot is usable next cycle.
- Empty with an allocation in the same cycle: no commit that cycle.
- Wrap-around: indices wrap modulo depth; the wrap bit toggles on every index overflow.
- `commit_ready` = 0: no retirement; `flush` = 0; state is held.

## Configuration
- Macro: `ROB_WB_GUARD_EN`.
- Defined:
  - adds output `wb_err` (1 bit, reset 0);
  - `wb_err` is sticky, set when any `wb_valid` port targets an index not in flight;
  - such writebacks are dropped.
- Undefined:
  - no `wb_err` port;
  - out-of-range writebacks are still dropped, with no indication.

## Test plan
- Reset, allocate 3 entries (idx 0,1,2), write back idx 2,0,1 one per cycle → commits in order 0,1,2; no cycle commits more than `COMMIT_W` = 2; `count` returns to 0.
- Fill all 16 entries → `alloc_ready` = 0 and `count` = 16; the 17th `alloc_valid` is dropped; one commit → `alloc_ready` = 1 the following cycle.
- Both WB ports target idx 5 with results 0xAAAA (port 0) and 0xBBBB (port 1) → idx 5 later commits 0xAAAA.
- Entries 0–5 allocated; idx 0 and 1 done, idx 1 mispredict → `commit_valid` = 2'b11 and `flush` = 1 in the same cycle; next cycle `count` = 0 and `alloc_idx` = 2.
- Hold `commit_ready` = 0 with 4 done entries for 3 cycles → `commit_valid` = 0 and `count` = 4; release → 2 retirements per cycle.
- With `ROB_WB_GUARD_EN` defined: empty ROB, writeback to idx 7 → `wb_err` = 1 and stays 1; idx 7 is not marked done.
